// File: rtl/psram_arbiter.sv
// Two-port arbiter in front of a single PSRAM controller: port A (CPU) and port B (video/DMA)
// share the controller with round-robin tie-breaking and a watchdog that aborts stuck transactions.
module psram_arbiter #(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned LAST_INIT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_a_stb,
  input  logic        i_a_we,
  input  logic [23:0] i_a_addr,
  input  logic [15:0] i_a_din,
  output logic        o_a_busy,
  output logic        o_a_done,
  output logic [15:0] o_a_dout,
  input  logic        i_b_stb,
  input  logic        i_b_we,
  input  logic [23:0] i_b_addr,
  input  logic [15:0] i_b_din,
  output logic        o_b_busy,
  output logic        o_b_done,
  output logic [15:0] o_b_dout,
  output logic        o_mem_stb,
  output logic        o_mem_we,
  output logic [23:0] o_mem_addr,
  output logic [15:0] o_mem_din,
  input  logic        i_mem_busy,
  input  logic        i_mem_done,
  input  logic [15:0] i_mem_dout,
  output logic        o_grant,
  output logic        o_timeout
);

  localparam int unsigned CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW:0] TLIM = (CW + 1)'(TIMEOUT);

  localparam logic [2:0] S_INIT        = 3'd0;
  localparam logic [2:0] S_IDLE        = 3'd1;
  localparam logic [2:0] S_ISSUE       = 3'd2;
  localparam logic [2:0] S_WAIT_ACCEPT = 3'd3;
  localparam logic [2:0] S_WAIT_DONE   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic          a_pend_q, a_pend_d, b_pend_q, b_pend_d;
  logic          a_we_q, a_we_d, b_we_q, b_we_d;
  logic [23:0]   a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [15:0]   a_din_q, a_din_d, b_din_q, b_din_d;
  logic          a_done_q, a_done_d, b_done_q, b_done_d;
  logic [15:0]   a_dout_q, a_dout_d, b_dout_q, b_dout_d;
  logic          mem_we_q, mem_we_d;
  logic [23:0]   mem_addr_q, mem_addr_d;
  logic [15:0]   mem_din_q, mem_din_d;
  logic          grant_q, grant_d, last_q, last_d, timeout_q, timeout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   cnt_inc;
  logic          sel;

  always_comb begin
    state_d    = state_q;
    a_pend_d   = a_pend_q;   b_pend_d   = b_pend_q;
    a_we_d     = a_we_q;     b_we_d     = b_we_q;
    a_addr_d   = a_addr_q;   b_addr_d   = b_addr_q;
    a_din_d    = a_din_q;    b_din_d    = b_din_q;
    a_done_d   = 1'b0;       b_done_d   = 1'b0;
    a_dout_d   = a_dout_q;   b_dout_d   = b_dout_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    grant_d    = grant_q;
    last_d     = last_q;
    timeout_d  = timeout_q;
    cnt_d      = cnt_q;
    cnt_inc    = {1'b0, cnt_q} + (CW + 1)'(1);
    sel        = 1'b0;

    // Capture is independent of state; a busy port ignores further strobes.
    if (i_a_stb && !a_pend_q) begin
      a_pend_d = 1'b1; a_we_d = i_a_we; a_addr_d = i_a_addr; a_din_d = i_a_din;
    end
    if (i_b_stb && !b_pend_q) begin
      b_pend_d = 1'b1; b_we_d = i_b_we; b_addr_d = i_b_addr; b_din_d = i_b_din;
    end

    case (state_q)
      S_INIT: if (!i_mem_busy && i_mem_done) state_d = S_IDLE;
      S_IDLE: begin
        if (a_pend_q || b_pend_q) begin
          sel        = (a_pend_q && b_pend_q) ? ~last_q : b_pend_q;
          grant_d    = sel;
          mem_we_d   = sel ? b_we_q   : a_we_q;
          mem_addr_d = sel ? b_addr_q : a_addr_q;
          mem_din_d  = sel ? b_din_q  : a_din_q;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_ACCEPT;
      end
      S_WAIT_ACCEPT, S_WAIT_DONE: begin
        if (state_q == S_WAIT_DONE && !i_mem_busy && i_mem_done) begin
          if (grant_q) begin
            b_done_d = 1'b1; b_pend_d = 1'b0;
            if (!mem_we_q) b_dout_d = i_mem_dout;
          end else begin
            a_done_d = 1'b1; a_pend_d = 1'b0;
            if (!mem_we_q) a_dout_d = i_mem_dout;
          end
          last_d  = grant_q;
          state_d = S_IDLE;
        end else if (cnt_inc >= TLIM) begin
          // Abort: release the granted port with its old read data, resync the controller in INIT.
          cnt_d     = TLIM[CW-1:0];
          timeout_d = 1'b1;
          if (grant_q) begin
            b_done_d = 1'b1; b_pend_d = 1'b0;
          end else begin
            a_done_d = 1'b1; a_pend_d = 1'b0;
          end
          state_d = S_INIT;
        end else begin
          cnt_d = cnt_inc[CW-1:0];
          if (state_q == S_WAIT_ACCEPT && i_mem_busy) state_d = S_WAIT_DONE;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_INIT;
      a_pend_q   <= 1'b0;  b_pend_q   <= 1'b0;
      a_we_q     <= 1'b0;  b_we_q     <= 1'b0;
      a_addr_q   <= '0;    b_addr_q   <= '0;
      a_din_q    <= '0;    b_din_q    <= '0;
      a_done_q   <= 1'b0;  b_done_q   <= 1'b0;
      a_dout_q   <= '0;    b_dout_q   <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      grant_q    <= 1'b0;
      last_q     <= LAST_INIT[0];
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_pend_q   <= a_pend_d;  b_pend_q   <= b_pend_d;
      a_we_q     <= a_we_d;    b_we_q     <= b_we_d;
      a_addr_q   <= a_addr_d;  b_addr_q   <= b_addr_d;
      a_din_q    <= a_din_d;   b_din_q    <= b_din_d;
      a_done_q   <= a_done_d;  b_done_q   <= b_done_d;
      a_dout_q   <= a_dout_d;  b_dout_q   <= b_dout_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_a_busy   = a_pend_q;
  assign o_b_busy   = b_pend_q;
  assign o_a_done   = a_done_q;
  assign o_b_done   = b_done_q;
  assign o_a_dout   = a_dout_q;
  assign o_b_dout   = b_dout_q;
  assign o_mem_stb  = (state_q == S_ISSUE);
  assign o_mem_we   = mem_we_q;
  assign o_mem_addr = mem_addr_q;
  assign o_mem_din  = mem_din_q;
  assign o_grant    = grant_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter with a small behavioural PSRAM controller model.
module tb_psram_arbiter;
  localparam int unsigned TMO = 255;

  logic        clk = 1'b0, rst;
  logic        a_stb, a_we, b_stb, b_we;
  logic [23:0] a_addr, b_addr;
  logic [15:0] a_din, b_din;
  logic        a_busy, a_done, b_busy, b_done;
  logic [15:0] a_dout, b_dout;
  logic        mem_stb, mem_we, mem_busy, mem_done, grant, tmo;
  logic [23:0] mem_addr;
  logic [15:0] mem_din, mem_dout;

  psram_arbiter #(.TIMEOUT(TMO), .LAST_INIT(1)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_din(a_din),
    .o_a_busy(a_busy), .o_a_done(a_done), .o_a_dout(a_dout),
    .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_din(b_din),
    .o_b_busy(b_busy), .o_b_done(b_done), .o_b_dout(b_dout),
    .o_mem_stb(mem_stb), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_din(mem_din),
    .i_mem_busy(mem_busy), .i_mem_done(mem_done), .i_mem_dout(mem_dout),
    .o_grant(grant), .o_timeout(tmo)
  );

  always #5 clk = ~clk;

  // Controller model knobs (driven by the stimulus block)
  logic        m_hold, m_hang;
  int          m_lat;
  logic [15:0] m_rdata;

  // Model and monitor state (written only by the negedge process)
  int          cyc = 0, stb_count = 0, stb_double = 0, addr_bad = 0;
  int          a_done_cnt = 0, b_done_cnt = 0, a_done_cyc = 0;
  logic        a_busy_at_done = 1'b0, b_busy_at_done = 1'b0, prev_stb = 1'b0;
  logic        m_active = 1'b0;
  int          m_cnt = 0;
  logic [23:0] trk_addr = '0;
  logic [15:0] trk_din = '0;
  logic        trk_we = 1'b0;
  logic [23:0] log_addr [16];
  logic [15:0] log_din  [16];
  logic        log_we   [16];
  logic        log_grant[16];
  int          log_cyc  [16];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mem_stb) begin
      if (prev_stb) stb_double = stb_double + 1;
      log_addr[stb_count[3:0]]  = mem_addr;
      log_din[stb_count[3:0]]   = mem_din;
      log_we[stb_count[3:0]]    = mem_we;
      log_grant[stb_count[3:0]] = grant;
      log_cyc[stb_count[3:0]]   = cyc;
      trk_addr = mem_addr; trk_din = mem_din; trk_we = mem_we;
      stb_count = stb_count + 1;
    end
    prev_stb = mem_stb;
    if (m_active && (mem_addr !== trk_addr || mem_din !== trk_din || mem_we !== trk_we))
      addr_bad = addr_bad + 1;
    if (a_done) begin a_done_cnt = a_done_cnt + 1; a_done_cyc = cyc; a_busy_at_done = a_busy; end
    if (b_done) begin b_done_cnt = b_done_cnt + 1; b_busy_at_done = b_busy; end
    if (m_hold) begin
      mem_busy = 1'b1; mem_done = 1'b0;
    end else if (mem_stb) begin
      mem_busy = !m_hang; mem_done = 1'b0; m_active = !m_hang; m_cnt = m_lat;
    end else if (m_active) begin
      if (m_cnt <= 1) begin
        mem_busy = 1'b0; mem_done = 1'b1; mem_dout = m_rdata; m_active = 1'b0;
      end else m_cnt = m_cnt - 1;
    end else begin
      mem_busy = 1'b0; mem_done = !m_hang;
    end
  end

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec = nvec + 1;
    assert (got === exp) else begin
      nerr = nerr + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic req_a(input logic we, input logic [23:0] addr, input logic [15:0] din);
    @(negedge clk);
    a_stb = 1'b1; a_we = we; a_addr = addr; a_din = din;
    @(negedge clk);
    a_stb = 1'b0;
  endtask

  task automatic req_b(input logic we, input logic [23:0] addr, input logic [15:0] din);
    @(negedge clk);
    b_stb = 1'b1; b_we = we; b_addr = addr; b_din = din;
    @(negedge clk);
    b_stb = 1'b0;
  endtask

  task automatic wait_done(input int ea, input int eb, input int budget, input string tag);
    int n = 0;
    while ((a_done_cnt < ea || b_done_cnt < eb) && n < budget) begin
      @(posedge clk);
      n = n + 1;
    end
    chk(tag, 32'(a_done_cnt >= ea && b_done_cnt >= eb), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_stb"},   32'(mem_stb),  32'd0);
    chk({pfx, "_we"},    32'(mem_we),   32'd0);
    chk({pfx, "_addr"},  32'(mem_addr), 32'd0);
    chk({pfx, "_din"},   32'(mem_din),  32'd0);
    chk({pfx, "_abusy"}, 32'(a_busy),   32'd0);
    chk({pfx, "_bbusy"}, 32'(b_busy),   32'd0);
    chk({pfx, "_adone"}, 32'(a_done),   32'd0);
    chk({pfx, "_bdone"}, 32'(b_done),   32'd0);
    chk({pfx, "_adout"}, 32'(a_dout),   32'd0);
    chk({pfx, "_bdout"}, 32'(b_dout),   32'd0);
    chk({pfx, "_grant"}, 32'(grant),    32'd0);
    chk({pfx, "_tmo"},   32'(tmo),      32'd0);
  endtask

  initial begin
    int s, sd, sb, da, db;
    logic [15:0] sa;
    rst = 1'b1; a_stb = 1'b0; b_stb = 1'b0; a_we = 1'b0; b_we = 1'b0;
    a_addr = '0; b_addr = '0; a_din = '0; b_din = '0;
    m_hold = 1'b1; m_hang = 1'b0; m_lat = 12; m_rdata = '0;
    repeat (3) @(negedge clk);
    #1 chk_reset_outputs("por");

    // Controller stays busy after reset: request must wait in INIT
    @(negedge clk) rst = 1'b0;
    req_a(1'b0, 24'h000123, 16'h0000);
    repeat (100) @(negedge clk);
    chk("hold_no_stb", 32'(stb_count), 32'd0);
    chk("hold_a_busy", 32'(a_busy), 32'd1);
    m_hold = 1'b0; m_rdata = 16'h5A5A;
    wait_done(1, 0, 200, "hold_done_seen");
    chk("hold_one_stb", 32'(stb_count), 32'd1);
    chk("hold_addr", 32'(log_addr[0]), 32'h000123);

    // Plain A read with 12-cycle latency
    s = stb_count; sd = stb_double; sb = addr_bad; m_rdata = 16'hBEEF;
    req_a(1'b0, 24'h000010, 16'hFFFF);
    wait_done(2, 0, 100, "rd_done_seen");
    chk("rd_stb_count", 32'(stb_count - s), 32'd1);
    chk("rd_stb_width", 32'(stb_double - sd), 32'd0);
    chk("rd_addr_stable", 32'(addr_bad - sb), 32'd0);
    chk("rd_addr", 32'(log_addr[s[3:0]]), 32'h000010);
    chk("rd_we", 32'(log_we[s[3:0]]), 32'd0);
    chk("rd_done_pulses", 32'(a_done_cnt), 32'd2);
    chk("rd_busy_at_done", 32'(a_busy_at_done), 32'd0);
    chk("rd_dout", 32'(a_dout), 32'hBEEF);

    // B write: data goes out, B read data untouched
    s = stb_count; sb = addr_bad; m_rdata = 16'h7777;
    req_b(1'b1, 24'h00ABCD, 16'h1234);
    wait_done(2, 1, 100, "wr_done_seen");
    chk("wr_we", 32'(log_we[s[3:0]]), 32'd1);
    chk("wr_addr", 32'(log_addr[s[3:0]]), 32'h00ABCD);
    chk("wr_din", 32'(log_din[s[3:0]]), 32'h1234);
    chk("wr_grant", 32'(log_grant[s[3:0]]), 32'd1);
    chk("wr_addr_stable", 32'(addr_bad - sb), 32'd0);
    chk("wr_done_pulses", 32'(b_done_cnt), 32'd1);
    chk("wr_busy_at_done", 32'(b_busy_at_done), 32'd0);
    chk("wr_bdout", 32'(b_dout), 32'd0);

    // Simultaneous strobes twice; B was served last so A wins the first tie
    s = stb_count; m_rdata = 16'h1111;
    @(negedge clk);
    a_stb = 1'b1; a_we = 1'b0; a_addr = 24'h000100;
    b_stb = 1'b1; b_we = 1'b0; b_addr = 24'h000200;
    @(negedge clk); a_stb = 1'b0; b_stb = 1'b0;
    wait_done(3, 2, 200, "rr1_done_seen");
    @(negedge clk);
    a_stb = 1'b1; a_addr = 24'h000101;
    b_stb = 1'b1; b_addr = 24'h000201;
    @(negedge clk); a_stb = 1'b0; b_stb = 1'b0;
    wait_done(4, 3, 200, "rr2_done_seen");
    chk("rr_g0", 32'(log_grant[4'(s)]),     32'd0);
    chk("rr_g1", 32'(log_grant[4'(s + 1)]), 32'd1);
    chk("rr_g2", 32'(log_grant[4'(s + 2)]), 32'd0);
    chk("rr_g3", 32'(log_grant[4'(s + 3)]), 32'd1);
    chk("rr_a0", 32'(log_addr[4'(s)]),      32'h000100);
    chk("rr_a1", 32'(log_addr[4'(s + 1)]),  32'h000200);
    chk("rr_a2", 32'(log_addr[4'(s + 2)]),  32'h000101);
    chk("rr_a3", 32'(log_addr[4'(s + 3)]),  32'h000201);
    chk("rr_bdout", 32'(b_dout), 32'h1111);

    // Controller never accepts: A aborts after 255 wait cycles, pending B survives
    m_hang = 1'b1; s = stb_count; sa = a_dout;
    req_a(1'b0, 24'h000300, 16'h0000);
    repeat (5) @(negedge clk);
    req_b(1'b0, 24'h000400, 16'h0000);
    wait_done(5, 3, 400, "to_done_seen");
    chk("to_flag", 32'(tmo), 32'd1);
    chk("to_latency", 32'(a_done_cyc - log_cyc[s[3:0]]), 32'(TMO + 1));
    chk("to_busy_at_done", 32'(a_busy_at_done), 32'd0);
    chk("to_adout", 32'(a_dout), 32'(sa));
    chk("to_b_pending", 32'(b_busy), 32'd1);
    repeat (10) @(negedge clk);
    chk("to_no_reissue", 32'(stb_count - s), 32'd1);
    m_hang = 1'b0; m_rdata = 16'h2222;
    wait_done(5, 4, 200, "to_b_done_seen");
    chk("to_b_grant", 32'(log_grant[4'(s + 1)]), 32'd1);
    chk("to_b_addr", 32'(log_addr[4'(s + 1)]), 32'h000400);
    chk("to_b_dout", 32'(b_dout), 32'h2222);
    chk("to_sticky", 32'(tmo), 32'd1);

    // Reset in WAIT_DONE with B pending
    m_lat = 50; s = stb_count;
    req_a(1'b0, 24'h000500, 16'h0000);
    repeat (3) @(negedge clk);
    req_b(1'b0, 24'h000600, 16'h0000);
    repeat (10) @(negedge clk);
    da = a_done_cnt; db = b_done_cnt;
    #2 rst = 1'b1;
    #1 chk_reset_outputs("mid");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    chk("mid_no_adone", 32'(a_done_cnt - da), 32'd0);
    chk("mid_no_bdone", 32'(b_done_cnt - db), 32'd0);
    chk("mid_no_stb", 32'(stb_count - s), 32'd1);
    chk("mid_a_idle", 32'(a_busy), 32'd0);
    chk("mid_b_idle", 32'(b_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
